// File: rtl/reg_desloc_universal_if.sv
// Bus for the universal shift register: parallel/serial data, mode select and
// automatic-serializer handshake flags.
interface reg_desloc_universal_if #(
  parameter int NBITS_DATA = 4
);
  logic [NBITS_DATA-1:0] Din;
  logic [2:0]            SEL;
  logic                  Din_serie;
  logic                  start;
  logic [NBITS_DATA-1:0] Dout;
  logic                  Dout_serie;
  logic                  Dout_msb;
  logic                  busy;
  logic                  done;

  modport master (
    output Din, SEL, Din_serie, start,
    input  Dout, Dout_serie, Dout_msb, busy, done
  );

  modport slave (
    input  Din, SEL, Din_serie, start,
    output Dout, Dout_serie, Dout_msb, busy, done
  );
endinterface

// File: rtl/reg_desloc_universal.sv
// Universal shift register (hold/load/shift/rotate) with an automatic
// LSB-first serializer started by a start pulse.
module reg_desloc_universal #(
  parameter int                    NBITS_DATA = 4,
  parameter logic [NBITS_DATA-1:0] RST_VALUE  = '0
) (
  input logic                   clk,
  input logic                   reset,
  reg_desloc_universal_if.slave bus
);

  localparam int CNT_W = $clog2(NBITS_DATA + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS_DATA - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [NBITS_DATA-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dout_d  = bus.Din;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          case (bus.SEL)
            3'b001:  dout_d = bus.Din;
            3'b010:  dout_d = {bus.Din_serie, dout_q[NBITS_DATA-1:1]};
            3'b011:  dout_d = {dout_q[NBITS_DATA-2:0], bus.Din_serie};
            3'b100:  dout_d = {dout_q[0], dout_q[NBITS_DATA-1:1]};
            3'b101:  dout_d = {dout_q[NBITS_DATA-2:0], dout_q[NBITS_DATA-1]};
            default: dout_d = dout_q;
          endcase
        end
      end
      SHIFT: begin
        // SEL and start are deliberately ignored until the frame completes.
        dout_d = {bus.Din_serie, dout_q[NBITS_DATA-1:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dout_q  <= RST_VALUE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Dout       = dout_q;
  assign bus.Dout_serie = dout_q[0];
  assign bus.Dout_msb   = dout_q[NBITS_DATA-1];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_reg_desloc_universal.sv
// Self-checking bench for reg_desloc_universal: directed steps plus random
// traffic, compared against a frame-level behavioural model.
module tb_reg_desloc_universal;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  // Reference model: register value, shifts still owed in the current frame.
  logic [N-1:0] m_dout;
  int           m_rem;
  logic         m_done;

  reg_desloc_universal_if #(.NBITS_DATA(N)) bus ();

  reg_desloc_universal #(.NBITS_DATA(N), .RST_VALUE('0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step();
    if (!reset) begin
      m_dout = '0; m_rem = 0; m_done = 1'b0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (bus.start) begin
        m_dout = bus.Din; m_rem = N;
      end else begin
        case (bus.SEL)
          3'd1: m_dout = bus.Din;
          3'd2: m_dout = (m_dout >> 1) | (N'(bus.Din_serie) << (N-1));
          3'd3: m_dout = (m_dout << 1) | N'(bus.Din_serie);
          3'd4: m_dout = (m_dout >> 1) | (N'(m_dout[0]) << (N-1));
          3'd5: m_dout = (m_dout << 1) | N'(m_dout[N-1]);
          default: ;
        endcase
      end
    end else begin
      m_dout = (m_dout >> 1) | (N'(bus.Din_serie) << (N-1));
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Dout"},  32'(bus.Dout),       32'(m_dout));
    chk({tag, ".serie"}, 32'(bus.Dout_serie), 32'(m_dout[0]));
    chk({tag, ".msb"},   32'(bus.Dout_msb),   32'(m_dout[N-1]));
    chk({tag, ".busy"},  32'(bus.busy),       32'(m_rem != 0));
    chk({tag, ".done"},  32'(bus.done),       32'(m_done));
  endtask

  // One clock: model consumes the inputs present at the edge, outputs sampled #1 later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic st, input logic [2:0] sel, input logic [N-1:0] din, input logic ser);
    bus.start = st; bus.SEL = sel; bus.Din = din; bus.Din_serie = ser;
  endtask

  int done_cnt;

  initial begin
    reset = 1'b0;
    m_dout = 'x; m_rem = 0; m_done = 1'b0;
    drive(1'b0, 3'd0, '0, 1'b0);

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 3'($urandom), N'($urandom), 1'($urandom));
      cycle("rst_hold");
      chk("rst_dout_zero", 32'(bus.Dout), 32'h0);
    end
    reset = 1'b1;

    // Parallel load then shift right
    drive(1'b0, 3'b001, 4'b1011, 1'b0); cycle("load");
    chk("load_1011", 32'(bus.Dout), 32'b1011);
    drive(1'b0, 3'b010, 4'b0000, 1'b1); cycle("shr1");
    chk("shr_1101", 32'(bus.Dout), 32'b1101);
    cycle("shr2");
    chk("shr_1110", 32'(bus.Dout), 32'b1110);

    // Rotates and shift left
    drive(1'b0, 3'b001, 4'b1000, 1'b0); cycle("load1000");
    drive(1'b0, 3'b101, 4'b0000, 1'b0); cycle("rotl");
    chk("rotl_0001", 32'(bus.Dout), 32'b0001);
    drive(1'b0, 3'b100, 4'b0000, 1'b0); cycle("rotr1");
    chk("rotr_1000", 32'(bus.Dout), 32'b1000);
    cycle("rotr2");
    chk("rotr_0100", 32'(bus.Dout), 32'b0100);
    drive(1'b0, 3'b011, 4'b0000, 1'b0); cycle("shl");
    chk("shl_1000", 32'(bus.Dout), 32'b1000);
    chk("shl_msb", 32'(bus.Dout_msb), 32'b1);
    drive(1'b0, 3'b110, 4'b1111, 1'b1); cycle("rsvd110");
    drive(1'b0, 3'b111, 4'b1111, 1'b1); cycle("rsvd111");
    chk("rsvd_hold", 32'(bus.Dout), 32'b1000);

    // Automatic serialization of 0110 with serial-in 1,0,1,1
    drive(1'b1, 3'b000, 4'b0110, 1'b0); cycle("ser_load");
    chk("ser_bit0", 32'(bus.Dout_serie), 32'b0);
    chk("ser_busy", 32'(bus.busy), 32'b1);
    drive(1'b0, 3'b001, 4'b1111, 1'b1); cycle("ser_s1");
    chk("ser_bit1", 32'(bus.Dout_serie), 32'b1);
    bus.Din_serie = 1'b0; cycle("ser_s2");
    chk("ser_bit2", 32'(bus.Dout_serie), 32'b1);
    bus.Din_serie = 1'b1; cycle("ser_s3");
    chk("ser_bit3", 32'(bus.Dout_serie), 32'b0);
    chk("ser_nodone", 32'(bus.done), 32'b0);
    bus.Din_serie = 1'b1; cycle("ser_s4");
    chk("ser_done", 32'(bus.done), 32'b1);
    chk("ser_idle", 32'(bus.busy), 32'b0);
    chk("ser_final", 32'(bus.Dout), 32'b1101);
    drive(1'b0, 3'b000, 4'b0000, 1'b0); cycle("ser_after");
    chk("ser_done_pulse", 32'(bus.done), 32'b0);

    // start held high with SEL toggling: back-to-back frames
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2) ? 3'b001 : 3'b000, N'($urandom), 1'($urandom));
      cycle("b2b");
      if (bus.done) done_cnt++;
      chk("b2b_excl", 32'(bus.done & bus.busy), 32'b0);
    end
    chk("b2b_done_count", 32'(done_cnt), 32'd4);
    drive(1'b0, 3'b000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cycle("b2b_drain");

    // Reset during the second shift of a frame, then restart
    drive(1'b1, 3'b000, 4'b1010, 1'b1); cycle("abort_load");
    drive(1'b0, 3'b000, 4'b0000, 1'b1); cycle("abort_s1");
    reset = 1'b0; cycle("abort_rst");
    chk("abort_dout", 32'(bus.Dout), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("abort_idle");
      chk("abort_nodone", 32'(bus.done), 32'b0);
    end
    drive(1'b1, 3'b000, 4'b0101, 1'b0); cycle("restart_load");
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) cycle("restart");
    chk("restart_done", 32'(bus.done), 32'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 29) != 0);
      drive(($urandom_range(0, 5) == 0), 3'($urandom), N'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
